// File: rtl/amstrad_io_pkg.sv
// Shared constants and state types for the CPC banking restore sequencer.
// Port addresses, data prefixes and the step-ordering helper live here.
package amstrad_io_pkg;

  localparam logic [15:0] IO_GA_PORT     = 16'h7F00;
  localparam logic [15:0] IO_ROMSEL_PORT = 16'hDF00;

  localparam logic [1:0] MMR_PFX  = 2'b11;
  localparam logic [2:0] MRER_PFX = 3'b100;
  localparam logic [2:0] RMR2_PFX = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RUN,
    ST_FIN
  } mmu_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } wr_phase_t;

  // Plus-only steps 1 and 2 are skipped on a classic CPC.
  function automatic logic [1:0] next_step(
    input logic [1:0] s,
    input logic       plus
  );
    logic [1:0] n;
    unique case (s)
      2'd0:    n = plus ? 2'd1 : 2'd3;
      2'd1:    n = 2'd2;
      default: n = 2'd3;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/io_write_cycle.sv
// One CPC I/O write: SETUP, io_WR STROBE, then HOLD.
// ack marks the last HOLD cycle; a go on that cycle chains the next write.
module io_write_cycle
  import amstrad_io_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int WR_CYC    = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic go,
  output logic wr,
  output logic ack
);

  localparam int MAX_AB = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
  localparam int MAXP   = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
  localparam int CW     = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC - 1);

  wr_phase_t     ph, ph_d;
  logic [CW-1:0] cnt, cnt_d;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ph  <= PH_IDLE;
      cnt <= '0;
    end else begin
      ph  <= ph_d;
      cnt <= cnt_d;
    end
  end

  always_comb begin
    ph_d  = ph;
    cnt_d = cnt + 1'b1;
    ack   = 1'b0;
    unique case (ph)
      PH_IDLE: begin
        cnt_d = '0;
        if (go) ph_d = PH_SETUP;
      end
      PH_SETUP: begin
        if (cnt == S_LAST) begin
          ph_d  = PH_STROBE;
          cnt_d = '0;
        end
      end
      PH_STROBE: begin
        if (cnt == W_LAST) begin
          ph_d  = PH_HOLD;
          cnt_d = '0;
        end
      end
      PH_HOLD: begin
        if (cnt == G_LAST) begin
          ack   = 1'b1;
          cnt_d = '0;
          ph_d  = go ? PH_SETUP : PH_IDLE;
        end
      end
      default: begin
        ph_d  = PH_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  assign wr = (ph == PH_STROBE);

endmodule

// File: rtl/amstrad_mmu_restore.sv
// Replays a saved MMR / MRER / RMR2 / ROM-select setup onto the CPC I/O bus.
// Holds the CPU off via bus_req/bus_gnt while the writes are issued.
module amstrad_mmu_restore
  import amstrad_io_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int WR_CYC    = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        plus_mode,
  input  logic [5:0]  ram_cfg,
  input  logic [7:0]  rom_bank,
  input  logic [4:0]  mrer_cfg,
  input  logic [4:0]  rmr2_cfg,
  input  logic        bus_gnt,
  output logic        bus_req,
  output logic        io_WR,
  output logic [15:0] A,
  output logic [7:0]  D,
  output logic        busy,
  output logic        done
);

  mmu_state_t  state, state_d;
  logic [1:0]  step, step_d, nxt;
  logic        plus_q;
  logic [5:0]  ram_q;
  logic [7:0]  rom_q;
  logic [4:0]  mrer_q, rmr2_q;
  logic [15:0] a_d, nxt_a;
  logic [7:0]  d_d, nxt_d;
  logic        latch, go, ack;

  io_write_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .WR_CYC    (WR_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_wr (
    .CLK   (CLK),
    .reset (reset),
    .go    (go),
    .wr    (io_WR),
    .ack   (ack)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      step   <= '0;
      plus_q <= 1'b0;
      ram_q  <= '0;
      rom_q  <= '0;
      mrer_q <= '0;
      rmr2_q <= '0;
      A      <= '0;
      D      <= '0;
    end else begin
      state <= state_d;
      step  <= step_d;
      A     <= a_d;
      D     <= d_d;
      if (latch) begin
        plus_q <= plus_mode;
        ram_q  <= ram_cfg;
        rom_q  <= rom_bank;
        mrer_q <= mrer_cfg;
        rmr2_q <= rmr2_cfg;
      end
    end
  end

  always_comb begin
    nxt   = next_step(step, plus_q);
    nxt_a = IO_GA_PORT;
    nxt_d = {MMR_PFX, ram_q};
    unique case (nxt)
      2'd1: nxt_d = {MRER_PFX, mrer_q};
      2'd2: nxt_d = {RMR2_PFX, rmr2_q};
      2'd3: begin
        nxt_a = IO_ROMSEL_PORT;
        nxt_d = rom_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    step_d  = step;
    a_d     = A;
    d_d     = D;
    latch   = 1'b0;
    go      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          latch   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_gnt) begin
          go      = 1'b1;
          step_d  = 2'd0;
          a_d     = IO_GA_PORT;
          d_d     = {MMR_PFX, ram_q};
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ack) begin
          if (step == 2'd3) begin
            state_d = ST_FIN;
            a_d     = '0;
            d_d     = '0;
          end else begin
            go     = 1'b1;
            step_d = nxt;
            a_d    = nxt_a;
            d_d    = nxt_d;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_req = (state == ST_REQ) || (state == ST_RUN);
  assign busy    = bus_req;
  assign done    = (state == ST_FIN);

endmodule

// File: tb/tb_amstrad_mmu_restore.sv
// Directed bench for amstrad_mmu_restore with a write monitor,
// a tiny MMU model and an A/D-vs-io_WR timing scoreboard.
module tb_amstrad_mmu_restore;

  localparam int SETUP_CYC = 2;
  localparam int WR_CYC    = 4;
  localparam int GAP_CYC   = 2;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        plus_mode = 1'b0;
  logic [5:0]  ram_cfg = '0;
  logic [7:0]  rom_bank = '0;
  logic [4:0]  mrer_cfg = '0;
  logic [4:0]  rmr2_cfg = '0;
  logic        bus_gnt = 1'b0;
  logic        bus_req, io_WR, busy, done;
  logic [15:0] A;
  logic [7:0]  D;

  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  amstrad_mmu_restore #(
    .SETUP_CYC (SETUP_CYC),
    .WR_CYC    (WR_CYC),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .plus_mode (plus_mode),
    .ram_cfg   (ram_cfg),
    .rom_bank  (rom_bank),
    .mrer_cfg  (mrer_cfg),
    .rmr2_cfg  (rmr2_cfg),
    .bus_gnt   (bus_gnt),
    .bus_req   (bus_req),
    .io_WR     (io_WR),
    .A         (A),
    .D         (D),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [23:0] wq[$];
  logic        prev_wr = 1'b0;
  logic [15:0] prev_a = '0;
  logic [7:0]  prev_d = '0;
  logic        chg;
  int          lowcnt = 100;
  int          stable = 100;
  int          wlen = 0;
  int          viol = 0;
  int          done_cnt = 0;
  logic [7:0]  m_mmr = '0, m_mrer = '0, m_rmr2 = '0, m_rom = '0;
  logic        m_act = 1'b0;
  logic [2:0]  m_page = '0;

  always @(negedge CLK) begin
    if (reset) begin
      prev_wr = 1'b0;
      prev_a  = A;
      prev_d  = D;
      lowcnt  = 100;
      stable  = 100;
      wlen    = 0;
    end else begin
      chg = (A !== prev_a) || (D !== prev_d);
      if (chg && lowcnt < GAP_CYC) viol++;
      if (io_WR && !prev_wr) begin
        if (chg || stable < SETUP_CYC) viol++;
        wq.push_back({A, D});
        if (A[15:8] == 8'h7F) begin
          if (D[7:6] == 2'b11) m_mmr = D;
          else if (D[7:5] == 3'b100) m_mrer = D;
          else if (D[7:5] == 3'b101) begin
            m_rmr2 = D;
            m_act  = 1'b1;
            m_page = D[2:0];
          end
        end else if (A[15:8] == 8'hDF) m_rom = D;
      end
      if (!io_WR && prev_wr && wlen != WR_CYC) viol++;
      wlen   = io_WR ? wlen + 1 : 0;
      lowcnt = io_WR ? 0 : lowcnt + 1;
      stable = chg ? 1 : stable + 1;
      if (done) done_cnt++;
      prev_wr = io_WR;
      prev_a  = A;
      prev_d  = D;
    end
  end

  function automatic logic [23:0] wq_at(input int i);
    if (i < wq.size()) return wq[i];
    return 24'hFFFFFF;
  endfunction

  task automatic clr;
    wq.delete();
    done_cnt = 0;
    m_mmr = '0; m_mrer = '0; m_rmr2 = '0; m_rom = '0;
    m_act = 1'b0; m_page = '0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, input int lim);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      if (done) begin
        n = i;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic wait_wr(input logic [7:0] dv, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge CLK);
      if (io_WR && D == dv) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int m;
    int bad;
    repeat (3) @(negedge CLK);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_io_WR", 32'(io_WR), 32'd0);
    chk("rst_A", 32'(A), 32'h0);
    chk("rst_D", 32'(D), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge CLK);

    // classic CPC: MMR then ROM select
    clr();
    plus_mode = 1'b0; ram_cfg = 6'b000_010; rom_bank = 8'h07; bus_gnt = 1'b1;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_bus_req", 32'(bus_req), 32'd1);
    wait_done(n, 100);
    chk("t1_cycles", 32'(n), 32'd18);
    chk("t1_fin_A", 32'(A), 32'h0);
    chk("t1_fin_D", 32'(D), 32'h0);
    chk("t1_fin_busy", 32'(busy), 32'd0);
    chk("t1_fin_req", 32'(bus_req), 32'd0);
    @(negedge CLK);
    chk("t1_nwr", 32'(wq.size()), 32'd2);
    chk("t1_w0", 32'(wq_at(0)), 32'h7F00C2);
    chk("t1_w1", 32'(wq_at(1)), 32'hDF0007);
    chk("t1_ndone", 32'(done_cnt), 32'd1);
    chk("t1_done_low", 32'(done), 32'd0);

    // Plus: all four writes
    clr();
    plus_mode = 1'b1; ram_cfg = 6'd0; rom_bank = 8'h00;
    mrer_cfg = 5'h1C; rmr2_cfg = 5'h0B;
    pulse_start();
    wait_done(n, 100);
    chk("t2_cycles", 32'(n), 32'd34);
    @(negedge CLK);
    chk("t2_nwr", 32'(wq.size()), 32'd4);
    chk("t2_w0", 32'(wq_at(0)), 32'h7F00C0);
    chk("t2_w1", 32'(wq_at(1)), 32'h7F009C);
    chk("t2_w2", 32'(wq_at(2)), 32'h7F00AB);
    chk("t2_w3", 32'(wq_at(3)), 32'hDF0000);
    chk("t2_mrer", 32'(m_mrer), 32'h9C);
    chk("t2_rmr2", 32'(m_rmr2), 32'hAB);
    chk("t2_rmr2_act", 32'(m_act), 32'd1);
    chk("t2_cart_page", 32'(m_page), 32'd3);
    chk("t2_mmr", 32'(m_mmr), 32'hC0);

    // grant withheld for 20 cycles
    clr();
    plus_mode = 1'b0; ram_cfg = 6'h3F; rom_bank = 8'hA5; bus_gnt = 1'b0;
    pulse_start();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus_req || io_WR || !busy) bad++;
      @(negedge CLK);
    end
    chk("t3_wait_bus", 32'(bad), 32'd0);
    bus_gnt = 1'b1;
    m = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge CLK);
      if (io_WR) begin
        m = i;
        break;
      end
    end
    chk("t3_wr_lat", 32'(m), 32'(SETUP_CYC + 1));
    wait_done(n, 100);
    chk("t3_done_lat", 32'(m + n - 1), 32'd17);
    @(negedge CLK);
    chk("t3_w0", 32'(wq_at(0)), 32'h7F00FF);
    chk("t3_w1", 32'(wq_at(1)), 32'hDF00A5);

    // second start during step-1 strobe must be ignored
    clr();
    plus_mode = 1'b1; ram_cfg = 6'h15; rom_bank = 8'h80;
    mrer_cfg = 5'h02; rmr2_cfg = 5'h18;
    pulse_start();
    wait_wr(8'h82, m);
    chk("t4_step1_seen", 32'(m > 0), 32'd1);
    pulse_start();
    wait_done(n, 100);
    chk("t4_done_seen", 32'(n > 0), 32'd1);
    repeat (20) @(negedge CLK);
    chk("t4_nwr", 32'(wq.size()), 32'd4);
    chk("t4_ndone", 32'(done_cnt), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_w0", 32'(wq_at(0)), 32'h7F00D5);
    chk("t4_w2", 32'(wq_at(2)), 32'h7F00B8);
    chk("t4_w3", 32'(wq_at(3)), 32'hDF0080);

    // reset during step-2 strobe, then a full replay
    clr();
    mrer_cfg = 5'h1C; rmr2_cfg = 5'h0B; ram_cfg = 6'd0; rom_bank = 8'h00;
    pulse_start();
    wait_wr(8'hAB, m);
    chk("t5_step2_seen", 32'(m > 0), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_wr", 32'(io_WR), 32'd0);
    chk("t5_rst_req", 32'(bus_req), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_A", 32'(A), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    repeat (10) @(negedge CLK);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    chk("t5_nwr_part", 32'(wq.size()), 32'd3);
    clr();
    pulse_start();
    wait_done(n, 100);
    chk("t5_replay_cyc", 32'(n), 32'd34);
    @(negedge CLK);
    chk("t5_replay_nwr", 32'(wq.size()), 32'd4);
    chk("t5_replay_w2", 32'(wq_at(2)), 32'h7F00AB);
    chk("t5_replay_done", 32'(done_cnt), 32'd1);

    chk("timing_viol", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/amstrad_mmu_restore.md
Name: amstrad_mmu_restore

Overview:
- Bus initiator that replays a saved banking configuration onto the CPC I/O write bus, after snapshot load or core re-init.
- Emits the same 7Fxx/DFxx io_WR cycles that the CPU would: MMR, Plus MRER, Plus RMR2, upper ROM select.
- Sits between the snapshot/OSD loader and the I/O bus mux in front of the MMU/GA. Holds the CPU off with a bus_req/bus_gnt handshake while it drives the bus.

Parameters:
- SETUP_CYC, 2, cycles A/D are stable before io_WR rises (min 1)
- WR_CYC, 4, cycles io_WR is held high (min 1)
- GAP_CYC, 2, cycles A/D are held after io_WR falls, before the next step (min 1)

Ports:
- CLK  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  1-cycle request; inputs below are latched on it
- plus_mode  in  1  1 = also issue MRER and RMR2 steps
- ram_cfg  in  6  MMR bits 5:0 (bank 5:3, map 2:0)
- rom_bank  in  8  upper ROM number for DFxx
- mrer_cfg  in  5  MRER bits 4:0
- rmr2_cfg  in  5  RMR2 bits 4:0
- bus_gnt  in  1  mux grants the I/O bus to this block
- bus_req  out  1  request for the I/O bus
- io_WR  out  1  write strobe toward the MMU/GA
- A  out  16  I/O address
- D  out  8  I/O data
- busy  out  1  sequence in progress
- done  out  1  1-cycle pulse when the sequence completes

Behaviour:
- Reset, asynchronous: state IDLE; bus_req, io_WR, busy and done are 0; A = 16'h0000; D = 8'h00; all latches are cleared.
- IDLE: when start = 1, latch all cfg inputs and plus_mode, set busy = 1, go to REQ. start is ignored while busy = 1.
- REQ: bus_req = 1; wait for bus_gnt = 1, then load step 0 and go to SETUP. bus_gnt is sampled only in REQ. The mux must hold the grant until bus_req falls.
- Step list, issued in this fixed order:
  - Step 0: A = 16'h7F00, D = {2'b11, ram_cfg}
  - Step 1 (plus_mode only): A = 16'h7F00, D = {3'b100, mrer_cfg}
  - Step 2 (plus_mode only): A = 16'h7F00, D = {3'b101, rmr2_cfg}
  - Step 3: A = 16'hDF00, D = rom_bank
  - When plus_mode = 0, steps 1 and 2 are skipped entirely; no bus activity is produced for them.
- SETUP: A/D are driven. After SETUP_CYC cycles go to STROBE.
- STROBE: io_WR = 1 for exactly WR_CYC cycles. A/D are unchanged. Then go to HOLD.
- HOLD: io_WR = 0; A/D are held for GAP_CYC cycles. Then:
  - if another step remains, load its A/D and go to SETUP;
  - otherwise go to FIN.
- FIN, one cycle: bus_req = 0, busy = 0, done = 1; A/D return to 0; go to IDLE.
- A start on the same cycle as FIN is ignored. A new start is accepted from the following IDLE cycle.
- Step counter is 2 bits; step index 3 is terminal (no wrap). Cycle counter width is clog2 of the largest parameter plus 1.
- Timing invariant: io_WR rises at least SETUP_CYC cycles after A/D change, and A/D change at least GAP_CYC cycles after io_WR falls. This guarantees exactly one rising edge per step at the MMU edge detector.
- Total cycles from grant to done:
  - steps × (SETUP_CYC + WR_CYC + GAP_CYC) + 1
  - steps = 4 when plus_mode = 1, steps = 2 when plus_mode = 0.
- Reset mid-sequence: outputs drop to their reset values immediately (asynchronous). No partial strobe is extended. No done pulse is issued.

Decomposition:
- Shared package amstrad_io_pkg holds:
  - port constants IO_GA_PORT = 16'h7F00 and IO_ROMSEL_PORT = 16'h DF00;
  - prefix constants MMR_PFX = 2'b11, MRER_PFX = 3'b100, RMR2_PFX = 3'b101;
  - the state enum typedef.
- One sub-module is natural: io_write_cycle (SETUP/STROBE/HOLD timer with a go/ack handshake). It is instantiated once, and the top-level FSM sequences the steps through it.

Test Plan:
- reset, start with plus_mode = 0, ram_cfg = 6'b000_010, rom_bank = 8'h07, gnt tied to 1 -> exactly 2 io_WR pulses of 4 cycles each: (7F00, C2) then (DF00, 07). done pulses 17 cycles after grant.
- plus_mode = 1, mrer_cfg = 5'h1C, rmr2_cfg = 5'h0B, ram_cfg = 0, rom_bank = 0 -> 4 writes in order: C0, 9C, AB, then DF00/00. An MMU model shows mrer = 9C, rmr2 = AB, rmr2_active = 1, cart_page = 3.
- bus_gnt held low for 20 cycles after start -> bus_req = 1 and io_WR = 0 throughout. The sequence begins SETUP_CYC cycles after gnt rises.
- Second start pulsed during STROBE of step 1 -> ignored; exactly 4 writes occur and a single done pulse.
- reset asserted in the middle of STROBE of step 2 -> io_WR, bus_req and busy go to 0 on the same edge; no done pulse. A following start replays the full sequence.
- Scoreboard check on all runs: A/D never change while io_WR = 1 or within GAP_CYC cycles after it falls.
